// File: rtl/encode_riscv.sv
`default_nettype none
// ============================================================================
// Module   : encode_riscv
// Purpose  : Encodes one internal micro-op per handshake into an RV32IM
//            instruction word and buffers {insn, pc, err} in a 2-entry FIFO.
//            Unencodable micro-ops (unknown op, out-of-range or misaligned
//            pc-relative offsets) produce err=1 with insn=0.
// Ports    : clk, reset_n (async, active-low)
//            in_valid/in_ready, in_op, in_dst/in_srcA/in_srcB, in_rvimm, in_pc
//            out_valid/out_ready, out_insn, out_pc, out_err
//            enc_count (accepted micro-ops), err_count (saturating errors)
// Revision : 1.0 - initial release
// ============================================================================

package encode_riscv_pkg;
    typedef enum logic [5:0] {
        OP_NOP, OP_II,
        OP_ADDU, OP_SUBU, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_LUI, OP_AUIPC,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_J, OP_JALR, OP_JR, OP_RET,
        OP_BREAK, OP_MONITOR
    } opcode_t;
endpackage

module encode_riscv
    import encode_riscv_pkg::*;
#(
    parameter int LG_PRF_ENTRIES = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  opcode_t                   in_op,
    input  logic [LG_PRF_ENTRIES-1:0] in_dst,
    input  logic [LG_PRF_ENTRIES-1:0] in_srcA,
    input  logic [LG_PRF_ENTRIES-1:0] in_srcB,
    input  logic [31:0]               in_rvimm,
    input  logic [31:0]               in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_insn,
    output logic [31:0]               out_pc,
    output logic                      out_err,
    output logic [31:0]               enc_count,
    output logic [15:0]               err_count
);

    localparam logic [6:0] C_OPC_OP  = 7'h33;
    localparam logic [6:0] C_OPC_IMM = 7'h13;
    localparam logic [6:0] C_OPC_LD  = 7'h03;
    localparam logic [6:0] C_OPC_ST  = 7'h23;

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [11:0] w_imm12;
    logic [31:0] w_off;
    logic        w_br_ok, w_jal_ok;
    logic [31:0] w_insn;
    logic        w_err;

    assign w_rd    = in_dst[4:0];
    assign w_rs1   = in_srcA[4:0];
    assign w_rs2   = in_srcB[4:0];
    assign w_imm12 = in_rvimm[11:0];
    assign w_off   = in_rvimm - in_pc;

    // An even offset fits the B/J immediate when all bits above its sign bit
    // replicate the sign bit.
    assign w_br_ok  = (w_off[31:12] == {20{w_off[12]}}) && !w_off[0];
    assign w_jal_ok = (w_off[31:20] == {12{w_off[20]}}) && !w_off[0];

    // Register-number bits above [4:0] are carried by the interface only.
    logic unused_regbits;
    assign unused_regbits = ^{in_dst[LG_PRF_ENTRIES-1:5], in_srcA[LG_PRF_ENTRIES-1:5],
                              in_srcB[LG_PRF_ENTRIES-1:5]};

    function automatic logic [31:0] f_btype(input logic [12:1] off, input logic [4:0] rs2,
                                            input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
    endfunction

    function automatic logic [31:0] f_jtype(input logic [20:1] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
    endfunction

    always_comb begin
        w_insn = 32'h0000_0000;
        w_err  = 1'b0;
        case (in_op)
            OP_ADDU:    w_insn = {7'h00, w_rs2, w_rs1, 3'd0, w_rd, C_OPC_OP};
            OP_SUBU:    w_insn = {7'h20, w_rs2, w_rs1, 3'd0, w_rd, C_OPC_OP};
            OP_SLL:     w_insn = {7'h00, w_rs2, w_rs1, 3'd1, w_rd, C_OPC_OP};
            OP_SLT:     w_insn = {7'h00, w_rs2, w_rs1, 3'd2, w_rd, C_OPC_OP};
            OP_SLTU:    w_insn = {7'h00, w_rs2, w_rs1, 3'd3, w_rd, C_OPC_OP};
            OP_XOR:     w_insn = {7'h00, w_rs2, w_rs1, 3'd4, w_rd, C_OPC_OP};
            OP_SRL:     w_insn = {7'h00, w_rs2, w_rs1, 3'd5, w_rd, C_OPC_OP};
            OP_SRA:     w_insn = {7'h20, w_rs2, w_rs1, 3'd5, w_rd, C_OPC_OP};
            OP_OR:      w_insn = {7'h00, w_rs2, w_rs1, 3'd6, w_rd, C_OPC_OP};
            OP_AND:     w_insn = {7'h00, w_rs2, w_rs1, 3'd7, w_rd, C_OPC_OP};
            OP_MUL:     w_insn = {7'h01, w_rs2, w_rs1, 3'd0, w_rd, C_OPC_OP};
            OP_MULH:    w_insn = {7'h01, w_rs2, w_rs1, 3'd1, w_rd, C_OPC_OP};
            OP_MULHU:   w_insn = {7'h01, w_rs2, w_rs1, 3'd3, w_rd, C_OPC_OP};
            OP_DIV:     w_insn = {7'h01, w_rs2, w_rs1, 3'd4, w_rd, C_OPC_OP};
            OP_DIVU:    w_insn = {7'h01, w_rs2, w_rs1, 3'd5, w_rd, C_OPC_OP};
            OP_REM:     w_insn = {7'h01, w_rs2, w_rs1, 3'd6, w_rd, C_OPC_OP};
            OP_REMU:    w_insn = {7'h01, w_rs2, w_rs1, 3'd7, w_rd, C_OPC_OP};
            OP_ADDI:    w_insn = {w_imm12, w_rs1, 3'd0, w_rd, C_OPC_IMM};
            OP_SLTI:    w_insn = {w_imm12, w_rs1, 3'd2, w_rd, C_OPC_IMM};
            OP_SLTIU:   w_insn = {w_imm12, w_rs1, 3'd3, w_rd, C_OPC_IMM};
            OP_XORI:    w_insn = {w_imm12, w_rs1, 3'd4, w_rd, C_OPC_IMM};
            OP_ORI:     w_insn = {w_imm12, w_rs1, 3'd6, w_rd, C_OPC_IMM};
            OP_ANDI:    w_insn = {w_imm12, w_rs1, 3'd7, w_rd, C_OPC_IMM};
            OP_SLLI:    w_insn = {7'h00, in_rvimm[4:0], w_rs1, 3'd1, w_rd, C_OPC_IMM};
            OP_SRLI:    w_insn = {7'h00, in_rvimm[4:0], w_rs1, 3'd5, w_rd, C_OPC_IMM};
            OP_SRAI:    w_insn = {7'h20, in_rvimm[4:0], w_rs1, 3'd5, w_rd, C_OPC_IMM};
            OP_LB:      w_insn = {w_imm12, w_rs1, 3'd0, w_rd, C_OPC_LD};
            OP_LH:      w_insn = {w_imm12, w_rs1, 3'd1, w_rd, C_OPC_LD};
            OP_LW:      w_insn = {w_imm12, w_rs1, 3'd2, w_rd, C_OPC_LD};
            OP_LBU:     w_insn = {w_imm12, w_rs1, 3'd4, w_rd, C_OPC_LD};
            OP_LHU:     w_insn = {w_imm12, w_rs1, 3'd5, w_rd, C_OPC_LD};
            OP_SB:      w_insn = {w_imm12[11:5], w_rs2, w_rs1, 3'd0, w_imm12[4:0], C_OPC_ST};
            OP_SH:      w_insn = {w_imm12[11:5], w_rs2, w_rs1, 3'd1, w_imm12[4:0], C_OPC_ST};
            OP_SW:      w_insn = {w_imm12[11:5], w_rs2, w_rs1, 3'd2, w_imm12[4:0], C_OPC_ST};
            OP_LUI:     w_insn = {in_rvimm[31:12], w_rd, 7'h37};
            OP_AUIPC: begin
                w_err = (w_off[11:0] != 12'h000);
                if (!w_err) w_insn = {w_off[31:12], w_rd, 7'h17};
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                w_err = !w_br_ok;
                if (w_br_ok) begin
                    case (in_op)
                        OP_BEQ:  w_insn = f_btype(w_off[12:1], w_rs2, w_rs1, 3'd0);
                        OP_BNE:  w_insn = f_btype(w_off[12:1], w_rs2, w_rs1, 3'd1);
                        OP_BLT:  w_insn = f_btype(w_off[12:1], w_rs2, w_rs1, 3'd4);
                        OP_BGE:  w_insn = f_btype(w_off[12:1], w_rs2, w_rs1, 3'd5);
                        OP_BLTU: w_insn = f_btype(w_off[12:1], w_rs2, w_rs1, 3'd6);
                        default: w_insn = f_btype(w_off[12:1], w_rs2, w_rs1, 3'd7);
                    endcase
                end
            end
            OP_JAL, OP_J: begin
                w_err = !w_jal_ok;
                if (w_jal_ok) w_insn = f_jtype(w_off[20:1], (in_op == OP_J) ? 5'd0 : w_rd);
            end
            OP_JALR:    w_insn = {w_imm12, w_rs1, 3'd0, w_rd, 7'h67};
            OP_JR,
            OP_RET:     w_insn = {w_imm12, w_rs1, 3'd0, 5'd0, 7'h67};
            OP_NOP:     w_insn = 32'h0000_0013;
            OP_BREAK:   w_insn = 32'h0000_0073;
            OP_MONITOR: w_insn = 32'h0010_0073;
            default:    w_err  = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // 2-entry FIFO and counters
    // ------------------------------------------------------------------
    logic [31:0] insn_q [2];
    logic [31:0] pc_q   [2];
    logic [1:0]  err_q;
    logic        wptr_q, rptr_q;
    logic [1:0]  count_q, count_d;
    logic [31:0] enc_count_q;
    logic [15:0] err_count_q;
    logic        w_push, w_pop;

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count_d   = count_q + {1'b0, w_push} - {1'b0, w_pop};

    assign out_insn  = insn_q[rptr_q];
    assign out_pc    = pc_q[rptr_q];
    assign out_err   = err_q[rptr_q];
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            insn_q[0]   <= 32'h0;
            insn_q[1]   <= 32'h0;
            pc_q[0]     <= 32'h0;
            pc_q[1]     <= 32'h0;
            err_q       <= 2'b00;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            count_q     <= 2'd0;
            enc_count_q <= 32'h0;
            err_count_q <= 16'h0;
        end else begin
            if (w_push) begin
                insn_q[wptr_q] <= w_insn;
                pc_q[wptr_q]   <= in_pc;
                err_q[wptr_q]  <= w_err;
                wptr_q         <= ~wptr_q;
                enc_count_q    <= enc_count_q + 32'd1;
                if (w_err && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 16'd1;
            end
            if (w_pop) rptr_q <= ~rptr_q;
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_encode_riscv.sv
`default_nettype none
// ============================================================================
// Module   : tb_encode_riscv
// Purpose  : Self-checking bench for encode_riscv. A queue-based reference
//            model computes instruction words arithmetically from the RV32
//            field layout and tracks FIFO contents and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encode_riscv;
    import encode_riscv_pkg::*;

    localparam int LG = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready, out_valid, out_ready, out_err;
    opcode_t       in_op;
    logic [LG-1:0] in_dst, in_srcA, in_srcB;
    logic [31:0]   in_rvimm, in_pc, out_insn, out_pc, enc_count;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    encode_riscv #(.LG_PRF_ENTRIES(LG)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_dst(in_dst), .in_srcA(in_srcA), .in_srcB(in_srcB),
        .in_rvimm(in_rvimm), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_insn(out_insn), .out_pc(out_pc), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] insn; logic [31:0] pc; logic err; } ent_t;
    ent_t        exp_q[$];
    int unsigned m_enc = 0;
    int unsigned m_err = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rt(logic [31:0] f7, logic [31:0] f3, logic [31:0] rs2,
                                       logic [31:0] rs1, logic [31:0] rd);
        return f7 * 32'd33554432 + rs2 * 32'd1048576 + rs1 * 32'd32768 + f3 * 32'd4096 + rd * 32'd128 + 32'h33;
    endfunction

    function automatic logic [31:0] it(logic [31:0] i12, logic [31:0] rs1, logic [31:0] f3,
                                       logic [31:0] rd, logic [31:0] opc);
        return i12 * 32'd1048576 + rs1 * 32'd32768 + f3 * 32'd4096 + rd * 32'd128 + opc;
    endfunction

    function automatic logic [31:0] st(logic [31:0] i12, logic [31:0] rs2, logic [31:0] rs1, logic [31:0] f3);
        return (i12 / 32) * 32'd33554432 + rs2 * 32'd1048576 + rs1 * 32'd32768 + f3 * 32'd4096
               + (i12 % 32) * 32'd128 + 32'h23;
    endfunction

    function automatic ent_t ref_encode(opcode_t op, logic [LG-1:0] dst, logic [LG-1:0] sa,
                                        logic [LG-1:0] sb, logic [31:0] imm, logic [31:0] pc);
        ent_t e;
        logic [31:0] rd, rs1, rs2, i12, sh, off, bf3;
        longint soff;
        rd = 32'(dst) % 32; rs1 = 32'(sa) % 32; rs2 = 32'(sb) % 32;
        i12 = imm % 4096; sh = imm % 32;
        off = imm - pc; soff = longint'($signed(off));
        e.pc = pc; e.err = 1'b0; e.insn = 32'h0; bf3 = 0;
        case (op)
            OP_ADDU: e.insn = rt(0, 0, rs2, rs1, rd);    OP_SUBU: e.insn = rt(32, 0, rs2, rs1, rd);
            OP_SLL:  e.insn = rt(0, 1, rs2, rs1, rd);    OP_SLT:  e.insn = rt(0, 2, rs2, rs1, rd);
            OP_SLTU: e.insn = rt(0, 3, rs2, rs1, rd);    OP_XOR:  e.insn = rt(0, 4, rs2, rs1, rd);
            OP_SRL:  e.insn = rt(0, 5, rs2, rs1, rd);    OP_SRA:  e.insn = rt(32, 5, rs2, rs1, rd);
            OP_OR:   e.insn = rt(0, 6, rs2, rs1, rd);    OP_AND:  e.insn = rt(0, 7, rs2, rs1, rd);
            OP_MUL:  e.insn = rt(1, 0, rs2, rs1, rd);    OP_MULH: e.insn = rt(1, 1, rs2, rs1, rd);
            OP_MULHU: e.insn = rt(1, 3, rs2, rs1, rd);   OP_DIV:  e.insn = rt(1, 4, rs2, rs1, rd);
            OP_DIVU: e.insn = rt(1, 5, rs2, rs1, rd);    OP_REM:  e.insn = rt(1, 6, rs2, rs1, rd);
            OP_REMU: e.insn = rt(1, 7, rs2, rs1, rd);
            OP_ADDI: e.insn = it(i12, rs1, 0, rd, 'h13); OP_SLTI: e.insn = it(i12, rs1, 2, rd, 'h13);
            OP_SLTIU: e.insn = it(i12, rs1, 3, rd, 'h13); OP_XORI: e.insn = it(i12, rs1, 4, rd, 'h13);
            OP_ORI:  e.insn = it(i12, rs1, 6, rd, 'h13); OP_ANDI: e.insn = it(i12, rs1, 7, rd, 'h13);
            OP_SLLI: e.insn = it(sh, rs1, 1, rd, 'h13);  OP_SRLI: e.insn = it(sh, rs1, 5, rd, 'h13);
            OP_SRAI: e.insn = it(32 * 32 + sh, rs1, 5, rd, 'h13);
            OP_LB:   e.insn = it(i12, rs1, 0, rd, 'h03); OP_LH:   e.insn = it(i12, rs1, 1, rd, 'h03);
            OP_LW:   e.insn = it(i12, rs1, 2, rd, 'h03); OP_LBU:  e.insn = it(i12, rs1, 4, rd, 'h03);
            OP_LHU:  e.insn = it(i12, rs1, 5, rd, 'h03);
            OP_SB:   e.insn = st(i12, rs2, rs1, 0);      OP_SH:   e.insn = st(i12, rs2, rs1, 1);
            OP_SW:   e.insn = st(i12, rs2, rs1, 2);
            OP_LUI:  e.insn = (imm / 4096) * 4096 + rd * 128 + 'h37;
            OP_AUIPC: if (off % 4096 != 0) e.err = 1'b1; else e.insn = (off / 4096) * 4096 + rd * 128 + 'h17;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (op)
                    OP_BEQ: bf3 = 0; OP_BNE: bf3 = 1; OP_BLT: bf3 = 4;
                    OP_BGE: bf3 = 5; OP_BLTU: bf3 = 6; default: bf3 = 7;
                endcase
                if (soff % 2 != 0 || soff < -4096 || soff > 4094) e.err = 1'b1;
                else e.insn = ((off / 4096) % 2) * 32'h8000_0000 + ((off / 32) % 64) * 33554432
                            + rs2 * 1048576 + rs1 * 32768 + bf3 * 4096 + ((off / 2) % 16) * 256
                            + ((off / 2048) % 2) * 128 + 'h63;
            end
            OP_JAL, OP_J: begin
                if (soff % 2 != 0 || soff < -1048576 || soff > 1048574) e.err = 1'b1;
                else e.insn = ((off / 1048576) % 2) * 32'h8000_0000 + ((off / 2) % 1024) * 2097152
                            + ((off / 2048) % 2) * 1048576 + ((off / 4096) % 256) * 4096
                            + ((op == OP_J) ? 0 : rd) * 128 + 'h6f;
            end
            OP_JALR: e.insn = it(i12, rs1, 0, rd, 'h67);
            OP_JR, OP_RET: e.insn = it(i12, rs1, 0, 0, 'h67);
            OP_NOP:     e.insn = 32'h0000_0013;
            OP_BREAK:   e.insn = 32'h0000_0073;
            OP_MONITOR: e.insn = 32'h0010_0073;
            default:    e.err = 1'b1;
        endcase
        return e;
    endfunction

    // One clock: decide handshakes from the model at the negedge, apply them
    // to the model at the posedge, return 1 time unit after the edge.
    task automatic tick();
        bit   acc, pop;
        ent_t e;
        @(negedge clk);
        acc = in_valid && (exp_q.size() < 2);
        pop = out_ready && (exp_q.size() != 0);
        e   = ref_encode(in_op, in_dst, in_srcA, in_srcB, in_rvimm, in_pc);
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(e);
            m_enc++;
            if (e.err && m_err < 65535) m_err++;
        end
        #1;
    endtask

    task automatic offer(opcode_t op, int d, int a, int b, logic [31:0] imm, logic [31:0] pc);
        in_valid = 1'b1; in_op = op; in_dst = LG'(d); in_srcA = LG'(a); in_srcB = LG'(b);
        in_rvimm = imm; in_pc = pc;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0;
        reset_n = 1'b0;
        exp_q.delete(); m_enc = 0; m_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        offer(OP_NOP, 0, 0, 0, 0, 0); in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if ({out_insn, out_pc, out_err} !== 65'h0) begin errors++;
            $display("FAIL reset_outputs got insn=%h pc=%h err=%b want zeros", out_insn, out_pc, out_err); end
        checks++; if (enc_count !== 32'h0 || err_count !== 16'h0) begin errors++;
            $display("FAIL reset_counters got enc=%0d err=%0d want 0 0", enc_count, err_count); end
        do_reset();
    endtask

    task automatic test_addi();
        do_reset();
        offer(OP_ADDI, 5, 6, 0, 32'hFFFF_FFFF, 32'h0000_0400);
        tick(); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_latency got valid=%b want 1", out_valid); end
        checks++; if (out_insn !== 32'hFFF3_0293 || out_err !== 1'b0) begin errors++;
            $display("FAIL addi_insn got %h err=%b want fff30293 err=0", out_insn, out_err); end
        checks++; if (out_pc !== 32'h0000_0400) begin errors++; $display("FAIL addi_pc got %h want 00000400", out_pc); end
        drain();
    endtask

    task automatic test_beq();
        do_reset();
        offer(OP_BEQ, 0, 1, 2, 32'h0000_0FF8, 32'h0000_1000);
        tick(); in_valid = 1'b0;
        checks++; if (out_insn !== 32'hFE20_8CE3 || out_err !== 1'b0) begin errors++;
            $display("FAIL beq_insn got %h err=%b want fe208ce3 err=0", out_insn, out_err); end
        drain();
        offer(OP_BEQ, 0, 1, 2, 32'h0000_3000, 32'h0000_1000);
        tick(); in_valid = 1'b0;
        checks++; if (out_insn !== 32'h0 || out_err !== 1'b1) begin errors++;
            $display("FAIL beq_range_err got %h err=%b want 00000000 err=1", out_insn, out_err); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL beq_err_count got %0d want 1", err_count); end
        drain();
    endtask

    task automatic test_mul();
        do_reset();
        offer(OP_MUL, 3, 4, 5, 32'h0, 32'h0);
        tick(); in_valid = 1'b0;
        checks++; if (out_insn !== 32'h0252_01B3 || out_err !== 1'b0) begin errors++;
            $display("FAIL mul_insn got %h err=%b want 025201b3 err=0", out_insn, out_err); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [3];
        want[0] = 32'hFFF3_0293; want[1] = 32'h0252_01B3; want[2] = 32'hFE20_8CE3;
        do_reset();
        offer(OP_ADDI, 5, 6, 0, 32'hFFFF_FFFF, 32'h10); tick();
        offer(OP_MUL, 3, 4, 5, 32'h0, 32'h20);          tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got in_ready=%b want 0", in_ready); end
        offer(OP_BEQ, 0, 1, 2, 32'h0FF8, 32'h1000);     tick();
        checks++; if (enc_count !== 32'd2 || out_insn !== want[0] || out_pc !== 32'h10) begin errors++;
            $display("FAIL b2b_hold got enc=%0d insn=%h pc=%h want 2 %h 00000010", enc_count, out_insn, out_pc, want[0]); end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_insn !== want[i]) begin errors++;
                $display("FAIL b2b_order[%0d] got valid=%b insn=%h want 1 %h", i, out_valid, out_insn, want[i]); end
        end
        checks++; if (enc_count !== 32'd3) begin errors++; $display("FAIL b2b_third got enc=%0d want 3", enc_count); end
        in_valid = 1'b0; tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got valid=%b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_simul_push_pop();
        int popped = 0;
        do_reset();
        offer(OP_ADDU, 1, 2, 3, 0, 32'h100); tick();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++; if (out_insn !== exp_q[0].insn || out_pc !== exp_q[0].pc) begin errors++;
                $display("FAIL simul_head[%0d] got %h/%h want %h/%h", i, out_insn, out_pc, exp_q[0].insn, exp_q[0].pc); end
            offer(opcode_t'($urandom_range(2, 35)), $urandom, $urandom, $urandom, $urandom, 32'h200 + 4 * i);
            tick(); popped++;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || exp_q.size() != 1) begin errors++;
                $display("FAIL simul_count[%0d] got valid=%b ready=%b want 1 1", i, out_valid, in_ready); end
        end
        checks++; if (enc_count !== 32'd21 || popped != 20) begin errors++;
            $display("FAIL simul_enc got enc=%0d pops=%0d want 21 20", enc_count, popped); end
        drain();
    endtask

    task automatic test_random();
        logic [31:0] pc;
        int          d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            pc = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(0, 3))
                0: begin d = $urandom_range(0, 10000) - 5000; if ($urandom_range(0, 7) != 0) d = d & -2; end
                1: d = $urandom_range(0, 4000000) - 2000000;
                2: d = ($urandom_range(0, 255) - 128) * 4096;
                default: d = $urandom;
            endcase
            offer(($urandom_range(0, 9) == 0) ? opcode_t'($urandom_range(51, 63)) : opcode_t'($urandom_range(0, 50)),
                  $urandom, $urandom, $urandom, pc + 32'(d), pc);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            checks++; if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() < 2)) begin errors++;
                $display("FAIL rand_flags[%0d] got valid=%b ready=%b depth=%0d", i, out_valid, in_ready, exp_q.size()); end
            if (exp_q.size() != 0) begin
                checks++; if ({out_insn, out_pc, out_err} !== {exp_q[0].insn, exp_q[0].pc, exp_q[0].err}) begin errors++;
                    $display("FAIL rand_head[%0d] got %h/%h/%b want %h/%h/%b", i, out_insn, out_pc, out_err,
                             exp_q[0].insn, exp_q[0].pc, exp_q[0].err); end
            end
            checks++; if (enc_count !== m_enc || err_count !== 16'(m_err)) begin errors++;
                $display("FAIL rand_counts[%0d] got %0d/%0d want %0d/%0d", i, enc_count, err_count, m_enc, m_err); end
        end
        drain();
    endtask

    task automatic test_err_saturation();
        do_reset();
        offer(OP_II, 0, 0, 0, 0, 0);
        out_ready = 1'b1;
        repeat (65540) tick();
        checks++; if (err_count !== 16'hFFFF || m_err != 65535) begin errors++;
            $display("FAIL err_saturate got %h want ffff", err_count); end
        checks++; if (enc_count !== 32'd65540) begin errors++; $display("FAIL sat_enc got %0d want 65540", enc_count); end
        checks++; if (out_insn !== 32'h0 || out_err !== 1'b1) begin errors++;
            $display("FAIL ii_encode got %h err=%b want 00000000 err=1", out_insn, out_err); end
        drain();
    endtask

    task automatic test_mid_reset();
        do_reset();
        offer(OP_LUI, 7, 0, 0, 32'hABCD_E123, 32'h40); tick();
        offer(OP_SW, 0, 3, 4, 32'h0000_0FFF, 32'h44);  tick();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++;
            $display("FAIL midrst_full got valid=%b ready=%b want 1 0", out_valid, in_ready); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL midrst_async got valid=%b ready=%b want 0 1", out_valid, in_ready); end
        checks++; if (enc_count !== 32'h0 || err_count !== 16'h0 || out_insn !== 32'h0 || out_pc !== 32'h0) begin errors++;
            $display("FAIL midrst_clear got enc=%0d err=%0d insn=%h pc=%h want zeros", enc_count, err_count, out_insn, out_pc); end
        in_valid = 1'b0;
        exp_q.delete(); m_enc = 0; m_err = 0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale got valid=%b want 0", out_valid); end
        offer(OP_LUI, 7, 0, 0, 32'hABCD_E123, 32'h40); tick();
        checks++; if (out_valid !== 1'b1 || out_insn !== 32'hABCD_E3B7) begin errors++;
            $display("FAIL midrst_after got valid=%b insn=%h want 1 abcde3b7", out_valid, out_insn); end
        drain();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_beq();
        test_mul();
        test_back_to_back();
        test_simul_push_pop();
        test_random();
        test_mid_reset();
        test_err_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
